// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW + 1R SRAM model with masked writes, collision bypass and power-on clear.
// Reads return data 1 cycle after the request; there is no backpressure: requests made while busy is high are dropped.
module sram_1rw1r_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 8,
    parameter int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
    parameter bit BYPASS      = 1'b1,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  busy,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % WMASK_WIDTH) != 0 || (NUM_WMASKS * WMASK_WIDTH) != DATA_WIDTH) begin : g_bad_cfg
        $error("sram_1rw1r_param: DATA_WIDTH must be NUM_WMASKS whole lanes of WMASK_WIDTH bits");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    clr_we;
    logic                    wr_en;
    logic                    rd0;
    logic                    rd1;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   wr_merge;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            if (INIT_CLEAR) state <= CLEAR;
            else            state <= READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset gates every enable so it wins over any port request.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        wr_en     = 1'b0;
        rd0       = 1'b0;
        rd1       = 1'b0;
        if (!rst0) begin
            case (state)
                CLEAR: begin
                    clr_we = 1'b1;
                    if (&ptr) state_nxt = READY;
                end
                READY: begin
                    wr_en = !csb0 && !web0;
                    rd0   = !csb0 && web0;
                    rd1   = !csb1;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);
    assign hit  = wr_en && rd1 && (addr0 == addr1) && (|wmask0);

    // Word as it will look after this cycle's masked write; also the bypass value.
    always_comb begin
        wr_merge = mem[addr0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) wr_merge[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) ptr <= '0;
        else if (clr_we) ptr <= ptr + 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (clr_we) mem[ptr] <= '0;
        else if (wr_en) mem[addr0] <= wr_merge;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0     <= '0;
            dout1     <= '0;
            dvalid0   <= 1'b0;
            dvalid1   <= 1'b0;
            collision <= 1'b0;
        end else begin
            dvalid0   <= rd0;
            dvalid1   <= rd1;
            collision <= hit;
            if (rd0) dout0 <= mem[addr0];
            if (rd1) dout1 <= (BYPASS && hit) ? wr_merge : mem[addr1];
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two 32-bit instances (bypass on/off) share stimulus, plus a 16-bit instance.
module tb_sram_1rw1r_param;

    logic        clk  = 1'b0;
    logic        rst0 = 1'b1;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [3:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic        csb1 = 1'b1;
    logic [3:0]  addr1 = '0;

    logic [31:0] dout0_o [2];
    logic [31:0] dout1_o [2];
    logic        dv0_o [2];
    logic        dv1_o [2];
    logic        busy_o [2];
    logic        coll_o [2];

    logic        c_csb0 = 1'b1;
    logic        c_web0 = 1'b1;
    logic [3:0]  c_wmask0 = '0;
    logic [3:0]  c_addr0 = '0;
    logic [15:0] c_din0 = '0;
    logic        c_csb1 = 1'b1;
    logic [3:0]  c_addr1 = '0;
    logic [15:0] c_dout0, c_dout1;
    logic        c_dv0, c_dv1, c_busy, c_coll;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        coll;
    } exp1_t;

    logic [31:0] q0a [$];
    logic [31:0] q0b [$];
    exp1_t       q1a [$];
    exp1_t       q1b [$];

    always #5 clk = ~clk;

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(8), .BYPASS(1'b1), .INIT_CLEAR(1'b1)) dut_a (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_o[0]), .dvalid0(dv0_o[0]), .csb1(csb1), .addr1(addr1), .dout1(dout1_o[0]),
        .dvalid1(dv1_o[0]), .busy(busy_o[0]), .collision(coll_o[0]));

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(8), .BYPASS(1'b0), .INIT_CLEAR(1'b1)) dut_b (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_o[1]), .dvalid0(dv0_o[1]), .csb1(csb1), .addr1(addr1), .dout1(dout1_o[1]),
        .dvalid1(dv1_o[1]), .busy(busy_o[1]), .collision(coll_o[1]));

    sram_1rw1r_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WMASK_WIDTH(4), .BYPASS(1'b1), .INIT_CLEAR(1'b1)) dut_c (
        .clk0(clk), .rst0(rst0), .csb0(c_csb0), .web0(c_web0), .wmask0(c_wmask0), .addr0(c_addr0), .din0(c_din0),
        .dout0(c_dout0), .dvalid0(c_dv0), .csb1(c_csb1), .addr1(c_addr1), .dout1(c_dout1),
        .dvalid1(c_dv1), .busy(c_busy), .collision(c_coll));

    function automatic int size0(int d);
        return (d == 0) ? q0a.size() : q0b.size();
    endfunction

    function automatic int size1(int d);
        return (d == 0) ? q1a.size() : q1b.size();
    endfunction

    function automatic logic [31:0] pop0(int d);
        if (d == 0) return q0a.pop_front();
        return q0b.pop_front();
    endfunction

    function automatic exp1_t pop1(int d);
        if (d == 0) return q1a.pop_front();
        return q1b.pop_front();
    endfunction

    // Scoreboard monitor: every strobe from the 32-bit instances consumes one expected entry.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (dv0_o[d]) begin
                checks++;
                if (size0(d) == 0) begin
                    errors++;
                    $display("FAIL dut%0d port0 unexpected dvalid0: dout0=%h, no read outstanding", d, dout0_o[d]);
                end else begin
                    logic [31:0] e0;
                    e0 = pop0(d);
                    if (dout0_o[d] !== e0) begin
                        errors++;
                        $display("FAIL dut%0d port0 read: dout0=%h expected %h", d, dout0_o[d], e0);
                    end
                end
            end
            if (dv1_o[d]) begin
                checks++;
                if (size1(d) == 0) begin
                    errors++;
                    $display("FAIL dut%0d port1 unexpected dvalid1: dout1=%h, no read outstanding", d, dout1_o[d]);
                end else begin
                    exp1_t e1;
                    e1 = pop1(d);
                    if (dout1_o[d] !== e1.d || coll_o[d] !== e1.coll) begin
                        errors++;
                        $display("FAIL dut%0d port1 read: dout1=%h collision=%b expected %h collision=%b",
                                 d, dout1_o[d], coll_o[d], e1.d, e1.coll);
                    end
                end
            end else if (coll_o[d] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d collision without port1 read: collision=%b expected 0", d, coll_o[d]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle of shared stimulus; expected responses go to the scoreboard as the request is issued.
    task automatic issue(input bit p0, input bit w, input logic [3:0] m, input logic [3:0] a0,
                         input logic [31:0] d0, input logic [31:0] e0, input bit p1, input logic [3:0] a1,
                         input logic [31:0] e1a, input logic [31:0] e1b, input bit ec);
        csb0   = !p0;
        web0   = !w;
        wmask0 = m;
        addr0  = a0;
        din0   = d0;
        csb1   = !p1;
        addr1  = a1;
        if (p0 && !w) begin
            q0a.push_back(e0);
            q0b.push_back(e0);
        end
        if (p1) begin
            q1a.push_back('{d: e1a, coll: ec});
            q1b.push_back('{d: e1b, coll: ec});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        csb1   = 1'b1;
        @(negedge clk);
    endtask

    task automatic count_busy(output int ca, output int cb, output int cc);
        ca = 0;
        cb = 0;
        cc = 0;
        for (int i = 0; i < 100 && (busy_o[0] || busy_o[1] || c_busy); i++) begin
            ca += int'(busy_o[0]);
            cb += int'(busy_o[1]);
            cc += int'(c_busy);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ca, cb, cc;

        // Reset state, then the first clear.
        @(negedge clk);
        rst0 = 1'b0;
        chk("reset busy", 32'(busy_o[0]), 32'd1);
        chk("reset dout0", dout0_o[0], 32'h0);
        chk("reset dout1", dout1_o[0], 32'h0);
        chk("reset dvalid0/dvalid1/collision", {29'd0, dv0_o[0], dv1_o[0], coll_o[0]}, 32'h0);
        count_busy(ca, cb, cc);
        chk("busy cycles dut_a", 32'(ca), 32'd16);
        chk("busy cycles dut_b", 32'(cb), 32'd16);
        chk("busy cycles dut_c", 32'(cc), 32'd16);

        // Dirty address 5 (also a collision), then reset and restart the clear at cycle 5.
        issue(1, 1, 4'hF, 4'd5, 32'h5A5A5A5A, 32'h0, 1, 4'd5, 32'h5A5A5A5A, 32'h0, 1'b1);
        idle();
        rst0 = 1'b1;
        @(negedge clk);
        rst0   = 1'b0;
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = 4'hF;
        addr0  = 4'd9;
        din0   = 32'hFFFFFFFF;
        csb1   = 1'b0;
        addr1  = 4'd9;
        repeat (5) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        count_busy(ca, cb, cc);
        csb0 = 1'b1;
        web0 = 1'b1;
        csb1 = 1'b1;
        chk("busy cycles after restart dut_a", 32'(ca), 32'd16);
        chk("busy cycles after restart dut_b", 32'(cb), 32'd16);

        // Whole array reads back zero, both ports back to back.
        for (int i = 0; i < 16; i++) begin
            issue(1, 0, 4'h0, 4'(15 - i), 32'h0, 32'h0, 1, 4'(i), 32'h0, 32'h0, 1'b0);
        end
        idle();

        // Lane-masked overwrite followed immediately by a read.
        issue(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 32'h0, 0, 4'd0, 32'h0, 32'h0, 1'b0);
        issue(1, 1, 4'h1, 4'd3, 32'h000000AA, 32'h0, 0, 4'd0, 32'h0, 32'h0, 1'b0);
        issue(1, 0, 4'h0, 4'd3, 32'h0, 32'hDEADBEAA, 0, 4'd0, 32'h0, 32'h0, 1'b0);
        idle();

        // Read-during-write collision: bypassed vs old data, then the committed word.
        issue(1, 1, 4'hF, 4'd7, 32'h11223344, 32'h0, 0, 4'd0, 32'h0, 32'h0, 1'b0);
        issue(1, 1, 4'hA, 4'd7, 32'hAABBCCDD, 32'h0, 1, 4'd7, 32'hAA22CC44, 32'h11223344, 1'b1);
        issue(0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 1, 4'd7, 32'hAA22CC44, 32'hAA22CC44, 1'b0);

        // Zero-mask write is a no-op and never collides.
        issue(1, 1, 4'h0, 4'd7, 32'hFFFFFFFF, 32'h0, 1, 4'd7, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
        issue(0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 1, 4'd7, 32'hAA22CC44, 32'hAA22CC44, 1'b0);

        // Both ports read one address, then outputs hold while idle.
        issue(1, 0, 4'h0, 4'd3, 32'h0, 32'hDEADBEAA, 1, 4'd3, 32'hDEADBEAA, 32'hDEADBEAA, 1'b0);
        idle();
        idle();
        idle();
        chk("hold dout0 dut_a", dout0_o[0], 32'hDEADBEAA);
        chk("hold dout1 dut_a", dout1_o[0], 32'hDEADBEAA);
        chk("hold dout1 dut_b", dout1_o[1], 32'hDEADBEAA);
        chk("idle dvalids dut_a", {30'd0, dv0_o[0], dv1_o[0]}, 32'h0);

        // 16-bit instance with 4-bit lanes.
        c_csb0   = 1'b0;
        c_web0   = 1'b0;
        c_wmask0 = 4'hF;
        c_addr0  = 4'd0;
        c_din0   = 16'h1234;
        @(negedge clk);
        c_web0  = 1'b1;
        c_csb1  = 1'b0;
        c_addr1 = 4'd0;
        chk("c write gives no dvalid0", 32'(c_dv0), 32'd0);
        @(negedge clk);
        c_csb0 = 1'b1;
        c_csb1 = 1'b1;
        chk("c dout0 same-address read", 32'(c_dout0), 32'h1234);
        chk("c dout1 same-address read", 32'(c_dout1), 32'h1234);
        chk("c dvalid0/dvalid1/collision", {29'd0, c_dv0, c_dv1, c_coll}, 32'h6);
        @(negedge clk);
        chk("c hold dout0", 32'(c_dout0), 32'h1234);
        chk("c hold dout1", 32'(c_dout1), 32'h1234);
        chk("c idle dvalids", {30'd0, c_dv0, c_dv1}, 32'h0);

        idle();
        chk("scoreboard drained", 32'(q0a.size() + q0b.size() + q1a.size() + q1b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
